// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter.
// State encoding, default pattern width and the length clamp.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int MAX_LEN_DEF = 16;

    function automatic int unsigned clamp_len(
        input int unsigned n,
        input int unsigned lim
    );
        return (n > lim) ? lim : n;
    endfunction

endpackage

// File: rtl/seq_gen_cnt.sv
// Loadable down-counter with zero flag.
// Load takes priority over decrement.
module seq_gen_cnt
    import seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = ld_val;
        end else if (dec) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first,
// repeated reps times with optional idle gaps between repeats.
module seq_gen
    import seq_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int GAP     = 0,
    parameter int REP_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [MAX_LEN-1:0]       pattern,
    input  logic [$clog2(MAX_LEN):0] nbits,
    input  logic [REP_W-1:0]         reps,
    output logic                     x,
    output logic                     x_valid,
    output logic                     busy,
    output logic                     done
);

    localparam int NB_W   = $clog2(MAX_LEN) + 1;
    localparam int IDX_W  = $clog2(MAX_LEN);
    localparam int GAP_W  = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int GAP_LD = (GAP > 0) ? GAP - 1 : 0;

    state_e state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [NB_W-1:0] nb_q, nb_d;
    logic x_q, x_d;
    logic xv_q, xv_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic [NB_W-1:0] nb_cl;
    logic [IDX_W-1:0] st_idx;
    logic [IDX_W-1:0] rl_idx;
    logic [IDX_W-1:0] nx_idx;

    logic idx_ld, idx_dec, idx_zero;
    logic [IDX_W-1:0] idx_ldv, idx_cnt;
    logic gap_ld, gap_dec, gap_zero;
    logic [GAP_W-1:0] gap_ldv, gap_cnt;
    logic rep_ld, rep_dec, rep_zero;
    logic [REP_W-1:0] rep_ldv, rep_cnt;
    logic unused_ok;

    // idx always names the bit currently on x; reps counts repeats still owed
    seq_gen_cnt #(.W(IDX_W)) u_idx (
        .clk    (clk),
        .rst    (rst),
        .load   (idx_ld),
        .ld_val (idx_ldv),
        .dec    (idx_dec),
        .cnt    (idx_cnt),
        .zero   (idx_zero)
    );

    seq_gen_cnt #(.W(GAP_W)) u_gap (
        .clk    (clk),
        .rst    (rst),
        .load   (gap_ld),
        .ld_val (gap_ldv),
        .dec    (gap_dec),
        .cnt    (gap_cnt),
        .zero   (gap_zero)
    );

    seq_gen_cnt #(.W(REP_W)) u_rep (
        .clk    (clk),
        .rst    (rst),
        .load   (rep_ld),
        .ld_val (rep_ldv),
        .dec    (rep_dec),
        .cnt    (rep_cnt),
        .zero   (rep_zero)
    );

    assign unused_ok = ^{gap_cnt, rep_cnt};

    always_comb begin
        nb_cl  = NB_W'(clamp_len(32'(nbits), 32'(MAX_LEN)));
        st_idx = IDX_W'(nb_cl - NB_W'(1));
        rl_idx = IDX_W'(nb_q - NB_W'(1));
        nx_idx = idx_cnt - IDX_W'(1);
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        nb_d    = nb_q;
        x_d     = 1'b0;
        xv_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        idx_ld  = 1'b0;
        idx_ldv = '0;
        idx_dec = 1'b0;
        gap_ld  = 1'b0;
        gap_ldv = GAP_W'(GAP_LD);
        gap_dec = 1'b0;
        rep_ld  = 1'b0;
        rep_ldv = '0;
        rep_dec = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pat_d  = pattern;
                        nb_d   = nb_cl;
                        busy_d = 1'b1;
                        if (nb_cl == '0 || reps == '0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_SHIFT;
                            x_d     = pattern[st_idx];
                            xv_d    = 1'b1;
                            idx_ld  = 1'b1;
                            idx_ldv = st_idx;
                            rep_ld  = 1'b1;
                            rep_ldv = reps - REP_W'(1);
                        end
                    end
                end
                ST_SHIFT: begin
                    if (!idx_zero) begin
                        idx_dec = 1'b1;
                        x_d     = pat_q[nx_idx];
                        xv_d    = 1'b1;
                    end else if (!rep_zero) begin
                        rep_dec = 1'b1;
                        if (GAP > 0) begin
                            state_d = ST_GAP;
                            gap_ld  = 1'b1;
                        end else begin
                            idx_ld  = 1'b1;
                            idx_ldv = rl_idx;
                            x_d     = pat_q[rl_idx];
                            xv_d    = 1'b1;
                        end
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_zero) begin
                        state_d = ST_SHIFT;
                        idx_ld  = 1'b1;
                        idx_ldv = rl_idx;
                        x_d     = pat_q[rl_idx];
                        xv_d    = 1'b1;
                    end else begin
                        gap_dec = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            nb_q    <= '0;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            nb_q    <= nb_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x       = x_q;
    assign x_valid = xv_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: one instance with GAP=0, one with GAP=2,
// sharing stimulus; each transfer is observed on the instance under test.
module tb_seq_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] pattern;
    logic [4:0]  nbits;
    logic [7:0]  reps;
    logic        x0, xv0, b0, d0;
    logic        x2, xv2, b2, d2;

    int n_chk;
    int n_err;

    seq_gen #(.MAX_LEN(16), .GAP(0), .REP_W(8)) u_dut0 (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .pattern (pattern),
        .nbits   (nbits),
        .reps    (reps),
        .x       (x0),
        .x_valid (xv0),
        .busy    (b0),
        .done    (d0)
    );

    seq_gen #(.MAX_LEN(16), .GAP(2), .REP_W(8)) u_dut2 (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .pattern (pattern),
        .nbits   (nbits),
        .reps    (reps),
        .x       (x2),
        .x_valid (xv2),
        .busy    (b2),
        .done    (d2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic go(input logic [15:0] p, input logic [4:0] n,
                      input logic [7:0] r);
        pattern = p;
        nbits   = n;
        reps    = r;
        start   = 1'b1;
    endtask

    task automatic settle();
        int k;
        k = 0;
        while ((b0 || b2) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("settle", {62'd0, b0, b2}, 64'd0);
    endtask

    // Observe one transfer on the selected instance after go() was called.
    task automatic run(input bit sel, input int poke_at, input int abort_at,
                       output logic [63:0] bits, output int nbit,
                       output int ndone, output int cdone, output int ngap,
                       output int nbusy, output int cend);
        logic sx, sv, sb, sd;
        int xbad;
        bits = '0;
        nbit = 0;
        ndone = 0;
        cdone = 0;
        ngap = 0;
        nbusy = 0;
        cend = 0;
        xbad = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            sx = sel ? x2 : x0;
            sv = sel ? xv2 : xv0;
            sb = sel ? b2 : b0;
            sd = sel ? d2 : d0;
            if (!sb && !sv && !sd) begin
                cend = c;
                break;
            end
            if (sv) begin
                bits = {bits[62:0], sx};
                nbit++;
            end else if (sx) begin
                xbad++;
            end
            if (sd) begin
                ndone++;
                cdone = c;
            end
            if (sb && !sv && !sd) ngap++;
            if (sb) nbusy++;
            start = (c == poke_at);
            if (c == poke_at) begin
                pattern = 16'hFFFF;
                nbits   = 5'd16;
                reps    = 8'd9;
            end
            abort = (c == abort_at);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        check("x_idle_zero", 64'(xbad), 64'd0);
        check("terminated", 64'(cend != 0), 64'd1);
    endtask

    logic [63:0] bits;
    int nbit, ndone, cdone, ngap, nbusy, cend;

    initial begin
        n_chk   = 0;
        n_err   = 0;
        rst     = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = '0;
        nbits   = '0;
        reps    = '0;
        #7;
        check("reset_outs0", {60'd0, x0, xv0, b0, d0}, 64'd0);
        check("reset_outs2", {60'd0, x2, xv2, b2, d2}, 64'd0);
        #6;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // single pass, GAP=0
        go(16'h0012, 5'd5, 8'd1);
        run(1'b0, 0, 0, bits, nbit, ndone, cdone, ngap, nbusy, cend);
        check("t1_bits", bits, 64'h12);
        check("t1_nbit", 64'(nbit), 64'd5);
        check("t1_done_cyc", 64'(cdone), 64'd6);
        check("t1_ndone", 64'(ndone), 64'd1);
        check("t1_busy", 64'(nbusy), 64'd6);

        // three back-to-back repeats, GAP=0
        settle();
        go(16'h0012, 5'd5, 8'd3);
        run(1'b0, 0, 0, bits, nbit, ndone, cdone, ngap, nbusy, cend);
        check("t1b_bits", bits, 64'h4A52);
        check("t1b_nbit", 64'(nbit), 64'd15);
        check("t1b_gap", 64'(ngap), 64'd0);
        check("t1b_done_cyc", 64'(cdone), 64'd16);

        // three repeats with GAP=2
        settle();
        go(16'h0012, 5'd5, 8'd3);
        run(1'b1, 0, 0, bits, nbit, ndone, cdone, ngap, nbusy, cend);
        check("t2_bits", bits, 64'h4A52);
        check("t2_nbit", 64'(nbit), 64'd15);
        check("t2_gap", 64'(ngap), 64'd4);
        check("t2_ndone", 64'(ndone), 64'd1);
        check("t2_done_cyc", 64'(cdone), 64'd20);

        // zero-length pattern
        settle();
        go(16'h0012, 5'd0, 8'd4);
        run(1'b1, 0, 0, bits, nbit, ndone, cdone, ngap, nbusy, cend);
        check("t3_nbit", 64'(nbit), 64'd0);
        check("t3_done_cyc", 64'(cdone), 64'd1);
        check("t3_busy", 64'(nbusy), 64'd1);

        // start during SHIFT is ignored
        settle();
        go(16'h0012, 5'd5, 8'd1);
        run(1'b0, 2, 0, bits, nbit, ndone, cdone, ngap, nbusy, cend);
        check("t4_bits", bits, 64'h12);
        check("t4_nbit", 64'(nbit), 64'd5);
        check("t4_done_cyc", 64'(cdone), 64'd6);

        // abort on the third bit, then a normal run
        settle();
        go(16'h0012, 5'd5, 8'd1);
        run(1'b1, 0, 3, bits, nbit, ndone, cdone, ngap, nbusy, cend);
        check("t5_bits", bits, 64'h4);
        check("t5_nbit", 64'(nbit), 64'd3);
        check("t5_ndone", 64'(ndone), 64'd0);
        check("t5_end", 64'(cend), 64'd4);
        go(16'h0012, 5'd5, 8'd1);
        run(1'b1, 0, 0, bits, nbit, ndone, cdone, ngap, nbusy, cend);
        check("t5_rerun_bits", bits, 64'h12);
        check("t5_rerun_done", 64'(cdone), 64'd6);

        // abort and start together: start dropped
        settle();
        go(16'h0012, 5'd5, 8'd1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_1", {62'd0, b0, xv0}, 64'd0);
        @(posedge clk);
        #1;
        check("abort_start_2", {62'd0, b0, d0}, 64'd0);

        // async reset in the middle of a gap
        settle();
        go(16'h0012, 5'd5, 8'd3);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("t6_in_gap", {62'd0, xv2, b2}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_outs", {60'd0, x2, xv2, b2, d2}, 64'd0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_idle", {60'd0, x2, xv2, b2, d2}, 64'd0);
        go(16'h0012, 5'd5, 8'd1);
        run(1'b1, 0, 0, bits, nbit, ndone, cdone, ngap, nbusy, cend);
        check("t6_rerun_bits", bits, 64'h12);

        // nbits beyond MAX_LEN is clamped
        settle();
        go(16'hA5C3, 5'd31, 8'd1);
        run(1'b0, 0, 0, bits, nbit, ndone, cdone, ngap, nbusy, cend);
        check("t7_bits", bits, 64'hA5C3);
        check("t7_nbit", 64'(nbit), 64'd16);
        check("t7_done_cyc", 64'(cdone), 64'd17);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
